// File: rtl/vga_pattern_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pattern_pkg : shared pattern IDs, scheduler states, colour levels |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package vga_pattern_pkg;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_GRAD  = 2'd3;

  localparam logic [1:0] SHOW    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] SWITCH  = 2'd2;

  localparam logic [9:0] COL_FULL = 10'd1023;
  localparam logic [9:0] COL_HALF = 10'd512;
  localparam logic [9:0] COL_ZERO = 10'd0;

endpackage
`default_nettype wire

// File: rtl/vga_pattern_color.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pattern_color : pattern ID + pixel coordinates -> RGB (comb)      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module vga_pattern_color
  import vga_pattern_pkg::*;
#(
  parameter int CHECK_SHIFT = 5
) (
  input  logic [1:0] iPattern,
  input  logic [9:0] iX,
  input  logic [9:0] iY,
  output logic [9:0] oRed,
  output logic [9:0] oGreen,
  output logic [9:0] oBlue
);

  logic w_checkOn;

  assign w_checkOn = iX[CHECK_SHIFT] ^ iY[CHECK_SHIFT];

  always_comb begin
    oRed   = COL_ZERO;
    oGreen = COL_ZERO;
    oBlue  = COL_ZERO;
    case (iPattern)
      PAT_SOLID: oGreen = COL_HALF;
      PAT_BARS: begin
        // Five bars of 128 columns; anything right of them stays black.
        case (iX[9:7])
          3'd0: begin oRed = COL_FULL; oGreen = COL_FULL; oBlue = COL_FULL; end
          3'd1: begin oRed = COL_FULL; oGreen = COL_FULL; end
          3'd2: begin oGreen = COL_FULL; oBlue = COL_FULL; end
          3'd3: oGreen = COL_FULL;
          3'd4: begin oRed = COL_FULL; oBlue = COL_FULL; end
          default: ;
        endcase
      end
      PAT_CHECK: begin
        if (w_checkOn) begin
          oRed   = COL_FULL;
          oGreen = COL_FULL;
          oBlue  = COL_FULL;
        end
      end
      default: begin
        oRed   = iX;
        oGreen = iY;
        oBlue  = COL_FULL - iX;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/vga_pattern_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pattern_scheduler : frame-aligned test-pattern sequencer + colour |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module vga_pattern_scheduler
  import vga_pattern_pkg::*;
#(
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int CHECK_SHIFT        = 5
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_N,
  input  logic [9:0] iVGA_X,
  input  logic [9:0] iVGA_Y,
  input  logic       iNext,
  input  logic       iAuto,
  input  logic       iHold,
  output logic [9:0] oRed,
  output logic [9:0] oGreen,
  output logic [9:0] oBlue,
  output logic [1:0] oPattern,
  output logic       oFrame_Start,
  output logic       oAck
);

  localparam logic [7:0] c_LAST_FRAME = 8'(FRAMES_PER_PATTERN - 1);

  logic [9:0] r_prevX, r_prevY;
  logic       r_prevNext;
  logic [7:0] r_frameCnt;
  logic [1:0] r_state, w_nextState;
  logic [1:0] r_pattern;
  logic       r_frameStart, r_ack;
  logic [9:0] r_red, r_green, r_blue;
  logic [9:0] w_red, w_green, w_blue;
  logic       w_frameStart, w_nextEdge, w_autoReq, w_request, w_doSwitch;

  // Previous coordinates reset to a non-origin value so a frame beginning
  // right after reset release is still recognised.
  assign w_frameStart = (iVGA_X == 10'd0) && (iVGA_Y == 10'd0) &&
                        !((r_prevX == 10'd0) && (r_prevY == 10'd0));
  assign w_nextEdge   = iNext & ~r_prevNext;
  assign w_autoReq    = w_frameStart & iAuto & ~iHold & (r_frameCnt == c_LAST_FRAME);
  assign w_request    = w_nextEdge | w_autoReq;

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_prevX      <= '1;
      r_prevY      <= '1;
      r_prevNext   <= 1'b0;
      r_frameStart <= 1'b0;
      r_frameCnt   <= 8'd0;
    end else begin
      r_prevX      <= iVGA_X;
      r_prevY      <= iVGA_Y;
      r_prevNext   <= iNext;
      r_frameStart <= w_frameStart;
      if (!iAuto)
        r_frameCnt <= 8'd0;
      else if (w_frameStart && !iHold)
        r_frameCnt <= (r_frameCnt == c_LAST_FRAME) ? 8'd0 : r_frameCnt + 8'd1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N)
      r_state <= SHOW;
    else
      r_state <= w_nextState;
  end

  // A request landing on a frame start needs no wait in PENDING.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SHOW:    if (w_request) w_nextState = w_frameStart ? SWITCH : PENDING;
      PENDING: if (w_frameStart) w_nextState = SWITCH;
      SWITCH:  w_nextState = SHOW;
      default: w_nextState = SHOW;
    endcase
  end

  always_comb begin
    w_doSwitch = (r_state == SWITCH);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_pattern <= PAT_SOLID;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_doSwitch;
      if (w_doSwitch)
        r_pattern <= r_pattern + 2'd1;
    end
  end

  vga_pattern_color #(
    .CHECK_SHIFT (CHECK_SHIFT)
  ) u_color (
    .iPattern (r_pattern),
    .iX       (iVGA_X),
    .iY       (iVGA_Y),
    .oRed     (w_red),
    .oGreen   (w_green),
    .oBlue    (w_blue)
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_red   <= 10'd0;
      r_green <= 10'd0;
      r_blue  <= 10'd0;
    end else begin
      r_red   <= w_red;
      r_green <= w_green;
      r_blue  <= w_blue;
    end
  end

  assign oRed         = r_red;
  assign oGreen       = r_green;
  assign oBlue        = r_blue;
  assign oPattern     = r_pattern;
  assign oFrame_Start = r_frameStart;
  assign oAck         = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_pattern_scheduler : scoreboard bench for the pattern scheduler |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_vga_pattern_scheduler;

  localparam int FPP = 2;
  localparam int CS  = 5;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_N   = 1'b0;
  logic [9:0] iVGA_X   = 10'd5;
  logic [9:0] iVGA_Y   = 10'd5;
  logic       iNext    = 1'b0;
  logic       iAuto    = 1'b0;
  logic       iHold    = 1'b0;
  logic [9:0] oRed, oGreen, oBlue;
  logic [1:0] oPattern;
  logic       oFrame_Start, oAck;

  vga_pattern_scheduler #(
    .FRAMES_PER_PATTERN (FPP),
    .CHECK_SHIFT        (CS)
  ) dut (
    .iVGA_CLK     (iVGA_CLK),
    .iRST_N       (iRST_N),
    .iVGA_X       (iVGA_X),
    .iVGA_Y       (iVGA_Y),
    .iNext        (iNext),
    .iAuto        (iAuto),
    .iHold        (iHold),
    .oRed         (oRed),
    .oGreen       (oGreen),
    .oBlue        (oBlue),
    .oPattern     (oPattern),
    .oFrame_Start (oFrame_Start),
    .oAck         (oAck)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  typedef struct {
    logic [29:0] rgb;
    logic [1:0]  pat;
    logic        fs;
    logic        ack;
    logic [1:0]  usedPat;
    logic [9:0]  x;
    logic [9:0]  y;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic       tNext = 1'b0, tAuto = 1'b0, tHold = 1'b0;
  logic [1:0] mPat;
  int         mState;
  logic [7:0] mCnt;
  logic       mPrevOrigin, mPrevNext;

  int frameX[13] = '{0, 1, 31, 32, 32, 100, 130, 260, 390, 520, 650, 639, 700};
  int frameY[13] = '{0, 0,  0,  0, 32, 200,  10,  10,  10,  10,  10, 479, 500};

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [29:0] refColour(input logic [1:0] p, input logic [9:0] x, input logic [9:0] y);
    logic [9:0] r, g, b;
    r = 0; g = 0; b = 0;
    case (p)
      2'd0: g = 10'd512;
      2'd1: case (x / 128)
              0: begin r = 1023; g = 1023; b = 1023; end
              1: begin r = 1023; g = 1023; end
              2: begin g = 1023; b = 1023; end
              3: g = 1023;
              4: begin r = 1023; b = 1023; end
              default: ;
            endcase
      2'd2: if ((((x >> CS) ^ (y >> CS)) & 10'd1) != 0) begin r = 1023; g = 1023; b = 1023; end
      default: begin r = x; g = y; b = 10'(1023 - x); end
    endcase
    return {r, g, b};
  endfunction

  task automatic modelReset();
    mPat = 0; mState = 0; mCnt = 0; mPrevOrigin = 0; mPrevNext = 0;
  endtask

  // Drive one pixel and push what the outputs must show after the next edge.
  task automatic step(input int x, input int y);
    exp_t e;
    logic origin, fs, edg, autoReq;
    @(negedge iVGA_CLK);
    iVGA_X = 10'(x); iVGA_Y = 10'(y);
    iNext = tNext; iAuto = tAuto; iHold = tHold;
    origin  = (x == 0) && (y == 0);
    fs      = origin && !mPrevOrigin;
    edg     = tNext && !mPrevNext;
    autoReq = 0;
    e.rgb = refColour(mPat, 10'(x), 10'(y));
    e.usedPat = mPat; e.x = 10'(x); e.y = 10'(y);
    e.fs  = fs;
    e.ack = (mState == 2);
    e.pat = (mState == 2) ? mPat + 2'd1 : mPat;
    q.push_back(e);
    if (!tAuto) mCnt = 0;
    else if (fs && !tHold) begin
      if (mCnt == 8'(FPP - 1)) begin mCnt = 0; autoReq = 1; end
      else mCnt = mCnt + 1;
    end
    case (mState)
      2: begin mPat = mPat + 2'd1; mState = 0; end
      1: if (fs) mState = 2;
      default: if (edg || autoReq) mState = fs ? 2 : 1;
    endcase
    mPrevOrigin = origin;
    mPrevNext   = tNext;
  endtask

  task automatic frame(input logic [12:0] nextMask);
    for (int i = 0; i < 13; i++) begin
      tNext = nextMask[i];
      step(frameX[i], frameY[i]);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_rgb"}, {2'b0, oRed, oGreen, oBlue}, 32'd0);
    checkValue({tag, "_pat"}, {30'b0, oPattern}, 32'd0);
    checkValue({tag, "_fs"},  {31'b0, oFrame_Start}, 32'd0);
    checkValue({tag, "_ack"}, {31'b0, oAck}, 32'd0);
  endtask

  task automatic resetPulse();
    @(posedge iVGA_CLK);
    #3;
    iRST_N = 1'b0;
    #1;
    checkAllZero("async_rst");
    modelReset();
    q.delete();
    repeat (2) @(posedge iVGA_CLK);
    @(negedge iVGA_CLK);
    iRST_N = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge iVGA_CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkValue("rgb", {2'b0, oRed, oGreen, oBlue}, {2'b0, e.rgb});
        checkValue("pattern", {30'b0, oPattern}, {30'b0, e.pat});
        checkValue("frame_start", {31'b0, oFrame_Start}, {31'b0, e.fs});
        checkValue("ack", {31'b0, oAck}, {31'b0, e.ack});
        if (e.usedPat == 2'd1 && e.x < 10'd128)
          checkValue("bar_white", {2'b0, oRed, oGreen, oBlue}, {2'b0, 10'd1023, 10'd1023, 10'd1023});
        if (e.usedPat == 2'd2 && e.x == 10'd31 && e.y == 10'd0)
          checkValue("check_31_0", {2'b0, oRed, oGreen, oBlue}, 32'd0);
        if (e.usedPat == 2'd2 && e.x == 10'd32 && e.y == 10'd0)
          checkValue("check_32_0", {2'b0, oRed, oGreen, oBlue}, {2'b0, 10'd1023, 10'd1023, 10'd1023});
        if (e.usedPat == 2'd2 && e.x == 10'd32 && e.y == 10'd32)
          checkValue("check_32_32", {2'b0, oRed, oGreen, oBlue}, 32'd0);
        if (e.usedPat == 2'd3 && e.x == 10'd639 && e.y == 10'd479)
          checkValue("grad_corner", {2'b0, oRed, oGreen, oBlue}, {2'b0, 10'd639, 10'd479, 10'd384});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    modelReset();
    repeat (3) @(posedge iVGA_CLK);
    #1;
    checkAllZero("reset");
    @(negedge iVGA_CLK);
    iRST_N = 1'b1;

    repeat (3) frame(13'h0000);           // idle, solid green
    frame(13'h0060); frame(13'h0000);     // mid-frame key press, held two cycles
    frame(13'h0054); frame(13'h0000);     // three presses in one frame
    frame(13'h0001); frame(13'h0000);     // press coincides with frame start

    tAuto = 1'b1;
    repeat (9) frame(13'h0000);
    tHold = 1'b1;
    repeat (3) frame(13'h0000);
    tHold = 1'b0;
    repeat (4) frame(13'h0000);
    repeat (3) frame(13'h0020);           // manual and auto in the same frame
    tAuto = 1'b0;
    frame(13'h0000);

    frame(13'h0020);                      // leaves a request pending
    resetPulse();
    repeat (2) frame(13'h0000);

    repeat (3) @(posedge iVGA_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
